// File: rtl/pdu_ring_buffer.sv
// PCIe ring buffer terminating the PDU generator write side.
// Owns tail, tracks host head, derives occupancy/almost_full, 2-cycle read port.
//
// Ports:
//  clk, rst_n                    clock, async active-low reset
//  wr_en/wr_addr/wr_data/wr_sop/wr_eop   flit write into RAM
//  wr_base_addr                  tail (next PDU header slot)
//  almost_full                   registered backpressure
//  update_valid/update_size      PDU commit, advances tail
//  head_valid/head_ptr           host head-pointer write
//  rd_en/rd_addr                 read request
//  rd_valid/rd_data/rd_sop/rd_eop read response, 2 cycles after rd_en
//  occupancy                     registered (tail - head) mod DEPTH
//  overflow_err                  sticky, commit exceeded free space
module pdu_ring_buffer #(
  parameter int PDU_AWIDTH = 12,
  parameter int DATA_W     = 512,
  parameter int AF_MARGIN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PDU_AWIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  output logic [PDU_AWIDTH-1:0] wr_base_addr,
  output logic                  almost_full,
  input  logic                  update_valid,
  input  logic [PDU_AWIDTH-1:0] update_size,
  input  logic                  head_valid,
  input  logic [PDU_AWIDTH-1:0] head_ptr,
  input  logic                  rd_en,
  input  logic [PDU_AWIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic [PDU_AWIDTH-1:0] occupancy,
  output logic                  overflow_err
);

  localparam int DEPTH = 1 << PDU_AWIDTH;
  localparam int RW    = DATA_W + 2;
  localparam logic [PDU_AWIDTH-1:0] MAX_OCC = '1;
  localparam logic [PDU_AWIDTH-1:0] AF_TH =
    PDU_AWIDTH'(AF_MARGIN);

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] ram_q;
  logic          rd_v1;

  logic [PDU_AWIDTH-1:0] tail_q;
  logic [PDU_AWIDTH-1:0] head_q;
  logic [PDU_AWIDTH-1:0] occ_q;
  logic [PDU_AWIDTH-1:0] tail_d;
  logic [PDU_AWIDTH-1:0] head_d;
  logic [PDU_AWIDTH-1:0] occ_d;
  logic [PDU_AWIDTH-1:0] free_q;
  logic                  commit;
  logic                  af_d;
  logic                  ovf_set;

  // Storage and registered read; nonblocking read gives old data
  // on a same-address read-during-write.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= {wr_sop, wr_eop, wr_data};
    if (rd_en)
      ram_q <= mem[rd_addr];
    if (rd_v1)
      {rd_sop, rd_eop, rd_data} <= ram_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_v1    <= rd_en;
      rd_valid <= rd_v1;
    end
  end

  // occ_q always equals tail_q - head_q, so free space
  // can be taken from the register directly.
  always_comb begin
    commit  = update_valid && (update_size != '0);
    free_q  = MAX_OCC - occ_q;
    tail_d  = tail_q;
    head_d  = head_q;
    if (commit)
      tail_d = tail_q + update_size;
    if (head_valid)
      head_d = head_ptr;
    occ_d   = tail_d - head_d;
    af_d    = (MAX_OCC - occ_d) < AF_TH;
    ovf_set = commit && (update_size > free_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q       <= '0;
      head_q       <= '0;
      occ_q        <= '0;
      almost_full  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      tail_q      <= tail_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      almost_full <= af_d;
      if (ovf_set)
        overflow_err <= 1'b1;
    end
  end

  assign wr_base_addr = tail_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_pdu_ring_buffer.sv
// Directed bench for pdu_ring_buffer.
// Inputs change on negedge; outputs sampled on the following negedge.
module tb_pdu_ring_buffer;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [11:0]  wr_addr;
  logic [511:0] wr_data;
  logic         wr_sop;
  logic         wr_eop;
  logic [11:0]  wr_base_addr;
  logic         almost_full;
  logic         update_valid;
  logic [11:0]  update_size;
  logic         head_valid;
  logic [11:0]  head_ptr;
  logic         rd_en;
  logic [11:0]  rd_addr;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic         rd_sop;
  logic         rd_eop;
  logic [11:0]  occupancy;
  logic         overflow_err;

  int pass_cnt;
  int total_cnt;

  pdu_ring_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_sop       (wr_sop),
    .wr_eop       (wr_eop),
    .wr_base_addr (wr_base_addr),
    .almost_full  (almost_full),
    .update_valid (update_valid),
    .update_size  (update_size),
    .head_valid   (head_valid),
    .head_ptr     (head_ptr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_sop       (rd_sop),
    .rd_eop       (rd_eop),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [511:0] mk(input int a);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(a);
    return {16{w}};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en        = 1'b0;
    wr_sop       = 1'b0;
    wr_eop       = 1'b0;
    update_valid = 1'b0;
    head_valid   = 1'b0;
    rd_en        = 1'b0;
  endtask

  task automatic wr(input int a, input logic s, input logic e);
    wr_en   = 1'b1;
    wr_addr = 12'(a);
    wr_data = mk(a);
    wr_sop  = s;
    wr_eop  = e;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    wr_addr = '0; wr_data = '0;
    update_size = '0; head_ptr = '0; rd_addr = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (wr_base_addr !== 12'd0)
      $display("FAIL reset_tail: got %0d expected 0", wr_base_addr);
    else pass_cnt++;
    total_cnt++;
    if (occupancy !== 12'd0)
      $display("FAIL reset_occ: got %0d expected 0", occupancy);
    else pass_cnt++;
    total_cnt++;
    if ({almost_full, rd_valid, overflow_err} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000",
               {almost_full, rd_valid, overflow_err});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    wr(1, 1'b0, 1'b0);
    wr(2, 1'b0, 1'b0);
    wr(3, 1'b0, 1'b1);
    wr(0, 1'b1, 1'b0);
    update_valid = 1'b1;
    update_size  = 12'd4;
    tick();
    idle();
    total_cnt++;
    if (wr_base_addr !== 12'd4)
      $display("FAIL basic_tail: got %0d expected 4", wr_base_addr);
    else pass_cnt++;
    total_cnt++;
    if (occupancy !== 12'd4)
      $display("FAIL basic_occ: got %0d expected 4", occupancy);
    else pass_cnt++;
    rd_en = 1'b1; rd_addr = 12'd0;
    tick();
    idle();
    total_cnt++;
    if (rd_valid !== 1'b0)
      $display("FAIL basic_rd_early: got %b expected 0", rd_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rd_valid, rd_sop, rd_eop} !== 3'b110 || rd_data !== mk(0))
      $display("FAIL basic_rd0: got v/s/e %b data %h expected 110 %h",
               {rd_valid, rd_sop, rd_eop}, rd_data, mk(0));
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rd_valid !== 1'b0)
      $display("FAIL basic_rd_drop: got %b expected 0", rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_rdw();
    wr(5, 1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = mk(99);
    rd_en = 1'b1; rd_addr = 12'd5;
    tick();
    idle();
    tick();
    total_cnt++;
    if (rd_valid !== 1'b1 || rd_data !== mk(5))
      $display("FAIL rdw_old: got v=%b %h expected 1 %h",
               rd_valid, rd_data, mk(5));
    else pass_cnt++;
    rd_en = 1'b1; rd_addr = 12'd5;
    tick();
    idle();
    tick();
    total_cnt++;
    if (rd_valid !== 1'b1 || rd_data !== mk(99))
      $display("FAIL rdw_new: got v=%b %h expected 1 %h",
               rd_valid, rd_data, mk(99));
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int a[4];
    a = '{4094, 4095, 0, 1};
    head_valid = 1'b1; head_ptr = 12'd4;
    tick();
    idle();
    update_valid = 1'b1; update_size = 12'd4090;
    head_valid = 1'b1; head_ptr = 12'd4094;
    tick();
    idle();
    total_cnt++;
    if (wr_base_addr !== 12'd4094 || occupancy !== 12'd0 ||
        overflow_err !== 1'b0)
      $display("FAIL wrap_setup: got tail %0d occ %0d ovf %b expected 4094 0 0",
               wr_base_addr, occupancy, overflow_err);
    else pass_cnt++;
    wr(4094, 1'b1, 1'b0);
    wr(4095, 1'b0, 1'b0);
    wr(0, 1'b0, 1'b0);
    wr(1, 1'b0, 1'b1);
    update_valid = 1'b1; update_size = 12'd4;
    tick();
    idle();
    total_cnt++;
    if (wr_base_addr !== 12'd2 || occupancy !== 12'd4)
      $display("FAIL wrap_tail: got tail %0d occ %0d expected 2 4",
               wr_base_addr, occupancy);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      rd_en   = (i < 4);
      rd_addr = (i < 4) ? 12'(a[i]) : 12'd0;
      tick();
      if (i >= 1 && i <= 4) begin
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== mk(a[i-1]) ||
            rd_sop !== (i == 1) || rd_eop !== (i == 4))
          $display("FAIL wrap_rd%0d: got v=%b s=%b e=%b %h expected %h",
                   i - 1, rd_valid, rd_sop, rd_eop, rd_data, mk(a[i-1]));
        else pass_cnt++;
      end
    end
    idle();
    total_cnt++;
    if (rd_valid !== 1'b0)
      $display("FAIL wrap_rd_end: got %b expected 0", rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_threshold();
    head_valid = 1'b1; head_ptr = 12'd35;
    tick();
    idle();
    total_cnt++;
    if (occupancy !== 12'd4063 || almost_full !== 1'b0)
      $display("FAIL thr_4063: got occ %0d af %b expected 4063 0",
               occupancy, almost_full);
    else pass_cnt++;
    update_valid = 1'b1; update_size = 12'd1;
    tick();
    idle();
    total_cnt++;
    if (occupancy !== 12'd4064 || almost_full !== 1'b1 ||
        wr_base_addr !== 12'd3)
      $display("FAIL thr_4064: got occ %0d af %b tail %0d expected 4064 1 3",
               occupancy, almost_full, wr_base_addr);
    else pass_cnt++;
    head_valid = 1'b1; head_ptr = 12'd36;
    tick();
    idle();
    total_cnt++;
    if (occupancy !== 12'd4063 || almost_full !== 1'b0)
      $display("FAIL thr_release: got occ %0d af %b expected 4063 0",
               occupancy, almost_full);
    else pass_cnt++;
    update_valid = 1'b1; update_size = 12'd0;
    tick();
    idle();
    total_cnt++;
    if (wr_base_addr !== 12'd3 || occupancy !== 12'd4063)
      $display("FAIL size_zero: got tail %0d occ %0d expected 3 4063",
               wr_base_addr, occupancy);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    update_valid = 1'b1; update_size = 12'd10;
    head_valid = 1'b1; head_ptr = 12'd42;
    tick();
    idle();
    total_cnt++;
    if (occupancy !== 12'd4067 || wr_base_addr !== 12'd13 ||
        overflow_err !== 1'b0 || almost_full !== 1'b1)
      $display("FAIL simul: got occ %0d tail %0d ovf %b af %b expected 4067 13 0 1",
               occupancy, wr_base_addr, overflow_err, almost_full);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    head_valid = 1'b1; head_ptr = 12'd19;
    tick();
    idle();
    total_cnt++;
    if (occupancy !== 12'd4090 || overflow_err !== 1'b0)
      $display("FAIL ovf_setup: got occ %0d ovf %b expected 4090 0",
               occupancy, overflow_err);
    else pass_cnt++;
    update_valid = 1'b1; update_size = 12'd10;
    tick();
    idle();
    total_cnt++;
    if (overflow_err !== 1'b1 || wr_base_addr !== 12'd23 ||
        occupancy !== 12'd4)
      $display("FAIL ovf_set: got ovf %b tail %0d occ %0d expected 1 23 4",
               overflow_err, wr_base_addr, occupancy);
    else pass_cnt++;
    update_valid = 1'b1; update_size = 12'd1;
    tick();
    idle();
    repeat (2) tick();
    total_cnt++;
    if (overflow_err !== 1'b1 || wr_base_addr !== 12'd24)
      $display("FAIL ovf_sticky: got ovf %b tail %0d expected 1 24",
               overflow_err, wr_base_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    rd_en = 1'b1; rd_addr = 12'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    total_cnt++;
    if ({rd_valid, almost_full, overflow_err} !== 3'b000 ||
        wr_base_addr !== 12'd0 || occupancy !== 12'd0)
      $display("FAIL rst_async: got v/af/ovf %b tail %0d occ %0d expected 000 0 0",
               {rd_valid, almost_full, overflow_err}, wr_base_addr, occupancy);
    else pass_cnt++;
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
    total_cnt++;
    if (rd_valid !== 1'b0 || wr_base_addr !== 12'd0)
      $display("FAIL rst_drop: got v=%b tail %0d expected 0 0",
               rd_valid, wr_base_addr);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_rdw();
    test_wrap();
    test_threshold();
    test_simultaneous();
    test_overflow();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
